// File: rtl/bf16_multiplier.sv
// bfloat16 multiplier with round-to-nearest-even, flush-to-zero and canonical NaN (build option BF16_MULT_PIPE2_EN).
// Latency: 1 cycle from A/B to O; 2 cycles when BF16_MULT_PIPE2_EN is defined.
// Backpressure: none; a new operand pair is accepted every cycle and O updates every cycle.
module bf16_multiplier #(
    parameter int DATA_TYPE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] A,
    input  logic [DATA_TYPE-1:0] B,
    output logic [DATA_TYPE-1:0] O
);

    if (DATA_TYPE != 16) begin : g_width_check
        $error("bf16_multiplier: only DATA_TYPE = 16 (BF16) is supported");
    end

    // Operand class carried alongside the datapath; NORM must encode as 0 for reset.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    // Field decode
    logic       sign_a, sign_b;
    logic [7:0] exp_a, exp_b;
    logic [6:0] man_a, man_b;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sign_a = A[15];
    assign sign_b = B[15];
    assign exp_a  = A[14:7];
    assign exp_b  = B[14:7];
    assign man_a  = A[6:0];
    assign man_b  = B[6:0];

    // Subnormals count as zero; the mantissa is ignored when exp is 0.
    assign a_zero = (exp_a == 8'h00);
    assign b_zero = (exp_b == 8'h00);
    assign a_inf  = (exp_a == 8'hFF) && (man_a == 7'h00);
    assign b_inf  = (exp_b == 8'hFF) && (man_b == 7'h00);
    assign a_nan  = (exp_a == 8'hFF) && (man_a != 7'h00);
    assign b_nan  = (exp_b == 8'hFF) && (man_b != 7'h00);

    // First-stage results: sign, biased exponent sum, raw significand product, class.
    logic               s1_sign;
    logic signed [9:0]  s1_exp;
    logic [15:0]        s1_prod;
    cls_t               s1_cls;

    assign s1_sign = sign_a ^ sign_b;
    assign s1_exp  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
    assign s1_prod = {8'd0, 1'b1, man_a} * {8'd0, 1'b1, man_b};

    // Special-case priority: NaN (incl. inf*0) beats inf, inf beats zero.
    always_comb begin
        s1_cls = CLS_NORM;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            s1_cls = CLS_NAN;
        end else if (a_inf || b_inf) begin
            s1_cls = CLS_INF;
        end else if (a_zero || b_zero) begin
            s1_cls = CLS_ZERO;
        end
    end

    // Second-stage inputs: either the first-stage wires or a pipeline register.
    logic               st_sign;
    logic signed [9:0]  st_exp;
    logic [15:0]        st_prod;
    cls_t               st_cls;

`ifdef BF16_MULT_PIPE2_EN
    logic               p_sign;
    logic signed [9:0]  p_exp;
    logic [15:0]        p_prod;
    cls_t               p_cls;

    // Split the multiply from normalize/round/pack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_sign <= 1'b0;
            p_exp  <= '0;
            p_prod <= '0;
            p_cls  <= CLS_NORM;
        end else begin
            p_sign <= s1_sign;
            p_exp  <= s1_exp;
            p_prod <= s1_prod;
            p_cls  <= s1_cls;
        end
    end

    assign st_sign = p_sign;
    assign st_exp  = p_exp;
    assign st_prod = p_prod;
    assign st_cls  = p_cls;
`else
    assign st_sign = s1_sign;
    assign st_exp  = s1_exp;
    assign st_prod = s1_prod;
    assign st_cls  = s1_cls;
`endif

    logic               hi;
    logic [6:0]         mant;
    logic               guard, sticky, round_up;
    logic [7:0]         mant_rnd;
    logic signed [9:0]  exp_fin;
    logic [15:0]        result;

    // Normalize, round to nearest even, then range-check and pack.
    always_comb begin
        hi       = st_prod[15];
        mant     = hi ? st_prod[14:8] : st_prod[13:7];
        guard    = hi ? st_prod[7]    : st_prod[6];
        sticky   = hi ? (|st_prod[6:0]) : (|st_prod[5:0]);
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {7'd0, round_up};
        // A carry out leaves mant_rnd[6:0] at zero and bumps the exponent.
        exp_fin  = st_exp + $signed({9'd0, hi}) + $signed({9'd0, mant_rnd[7]});
        result   = {st_sign, exp_fin[7:0], mant_rnd[6:0]};
        case (st_cls)
            CLS_NAN:  result = 16'h7FC0;
            CLS_INF:  result = {st_sign, 8'hFF, 7'h00};
            CLS_ZERO: result = {st_sign, 15'h0000};
            default: begin
                if (exp_fin >= 10'sd255) begin
                    result = {st_sign, 8'hFF, 7'h00};
                end else if (exp_fin <= 10'sd0) begin
                    result = {st_sign, 15'h0000};
                end
            end
        endcase
    end

    // Output register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            O <= '0;
        end else begin
            O <= result;
        end
    end

endmodule

// File: tb/tb_bf16_multiplier.sv
// Self-checking bench for bf16_multiplier: directed table plus random operands against a real-arithmetic model.
// Latency: follows the build, 1 cycle or 2 with BF16_MULT_PIPE2_EN.
// Backpressure: none; one operand pair is driven every cycle.
module tb_bf16_multiplier;

`ifdef BF16_MULT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] A, B, O;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] e;
        string       tag;
    } exp_t;

    exp_t q[$];

    bf16_multiplier #(.DATA_TYPE(16)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .O   (O)
    );

    always #5 clk = ~clk;

    // Reference: exact product in real arithmetic, rounded to 8 significant bits (RNE).
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic       s;
        int         ea, eb, ma, mb, k, qv, be;
        real        v, scaled, frac;
        logic       za, zb, ia, ib, na, nb;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = int'(a[6:0]);
        mb = int'(b[6:0]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (ma == 0);
        ib = (eb == 255) && (mb == 0);
        na = (ea == 255) && (ma != 0);
        nb = (eb == 255) && (mb != 0);
        if (na || nb || (ia && zb) || (za && ib)) return 16'h7FC0;
        if (ia || ib) return {s, 8'hFF, 7'h00};
        if (za || zb) return {s, 15'h0000};
        v = (1.0 + real'(ma) / 128.0) * (1.0 + real'(mb) / 128.0);
        k = (ea - 127) + (eb - 127);
        while (v >= 2.0) begin
            v = v / 2.0;
            k = k + 1;
        end
        scaled = v * 128.0;
        qv     = $rtoi(scaled);
        frac   = scaled - real'(qv);
        if (frac > 0.5 || (frac == 0.5 && (qv % 2) == 1)) qv = qv + 1;
        if (qv == 256) begin
            qv = 128;
            k  = k + 1;
        end
        be = k + 127;
        if (be >= 255) return {s, 8'hFF, 7'h00};
        if (be <= 0) return {s, 15'h0000};
        return {s, 8'(be), 7'(qv)};
    endfunction

    task automatic chk(input logic [15:0] got, input logic [15:0] exp, input string tag);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: O=%h expected %h", tag, got, exp);
        end
    endtask

    // Drive one pair just after a rising edge; check the pair driven LAT cycles earlier.
    task automatic step(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        if (q.size() == LAT) begin
            x = q.pop_front();
            chk(O, x.e, x.tag);
        end
        A     = a;
        B     = b;
        x.e   = exp;
        x.tag = tag;
        q.push_back(x);
    endtask

    localparam int ND = 19;
    logic [15:0] da [ND] = '{16'h4040, 16'h4100, 16'h4480, 16'h3FA0, 16'h3F81, 16'h3FC0,
                             16'h3F81, 16'hC040, 16'hC040, 16'h7F80, 16'h7F80, 16'h7FC1,
                             16'h8000, 16'h0001, 16'h7F00, 16'h0080, 16'hFF00, 16'h3F80,
                             16'h4000};
    logic [15:0] db [ND] = '{16'h3F80, 16'h449B, 16'h4600, 16'h4020, 16'h3F81, 16'h3F88,
                             16'h3FFF, 16'h3F80, 16'hC040, 16'h4000, 16'h0000, 16'h3F80,
                             16'h4000, 16'h4000, 16'h4000, 16'h0080, 16'h7F00, 16'h3F80,
                             16'h4000};
    logic [15:0] de [ND] = '{16'h4040, 16'h461B, 16'h4B00, 16'h4048, 16'h3F82, 16'h3FCC,
                             16'h4000, 16'hC040, 16'h4110, 16'h7F80, 16'h7FC0, 16'h7FC0,
                             16'h8000, 16'h0000, 16'h7F80, 16'h0000, 16'hFF80, 16'h3F80,
                             16'h4080};

    initial begin
        logic [15:0] ra, rb;
        exp_t        x;
        rst = 1'b1;
        A   = 16'h0000;
        B   = 16'h0000;
        #12;
        chk(O, 16'h0000, "reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Directed products, back to back.
        for (int i = 0; i < ND; i++) begin
            step(da[i], db[i], de[i], $sformatf("dir%0d_%h*%h", i, da[i], db[i]));
        end

        // Asynchronous reset between edges while results are streaming.
        #2;
        rst = 1'b1;
        #1;
        chk(O, 16'h0000, "rst_async");
        @(posedge clk);
        #1;
        chk(O, 16'h0000, "rst_hold");
        q.delete();
        A     = 16'h4040;
        B     = 16'h4000;
        x.e   = 16'h40C0;
        x.tag = "post_rst_first";
        q.push_back(x);
        #3;
        rst = 1'b0;
        step(16'h3FA0, 16'h4020, 16'h4048, "post_rst_second");

        // Random operands, with exponent forced to 00/FF now and then.
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra[14:7] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 7) == 0) rb[14:7] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 3) == 0) rb[14:7] = 8'(254 - int'(ra[14:7]) + $urandom_range(0, 4));
            step(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d_%h*%h", i, ra, rb));
        end

        // Drain the pipeline.
        for (int i = 0; i < LAT; i++) begin
            step(16'h0000, 16'h0000, 16'h0000, "drain");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
